// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU fed by the ALU controller's 3-bit code.
// Single-cycle ops (add/sub/and/or/slt) finish on the start edge.
// Code 3'b011 runs an iterative shift-add multiply that returns the low WIDTH bits.
// Optional macro ALU_MUL_EARLY_TERM_EN: the multiply stops as soon as the
// remaining multiplier bits are zero.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       AluOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] ar, br, acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] alu_res, acc_nxt;
  logic             mul_last;

  // Single-cycle function of the live operands; reserved codes give 0.
  always_comb begin
    alu_res = '0;
    case (AluOperation)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step; the last step is folded straight into result.
  assign acc_nxt = acc + (br[0] ? ar : '0);

`ifdef ALU_MUL_EARLY_TERM_EN
  assign mul_last = (cnt == CNT_W'(WIDTH-1)) || (br[WIDTH-1:1] == '0);
`else
  assign mul_last = (cnt == CNT_W'(WIDTH-1));
`endif

  // Control FSM plus datapath registers; done is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      ar     <= '0;
      br     <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (AluOperation == OP_MUL) begin
`ifdef ALU_MUL_EARLY_TERM_EN
              if (B == '0) begin
                result <= '0;
                zero   <= 1'b1;
                done   <= 1'b1;
              end else
`endif
              begin
                ar    <= A;
                br    <= B;
                acc   <= '0;
                cnt   <= '0;
                state <= MUL;
                busy  <= 1'b1;
              end
            end else begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= acc_nxt;
          ar  <= ar << 1;
          br  <= br >> 1;
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            result <= acc_nxt;
            zero   <= (acc_nxt == '0);
            done   <= 1'b1;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected result and
// completion cycle, a negedge monitor pops and compares on every done pulse.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, zero;
  logic [W-1:0] result;

  alu_exec_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .AluOperation(op),
    .A(a), .B(b), .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    string        name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model straight from the operation table.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    case (o)
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b111:  return (int'($signed(x)) < int'($signed(y))) ? 1 : 0;
      3'b011:  begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; return p[W-1:0]; end
      default: return '0;
    endcase
  endfunction

  // Edges from the start edge to done, inclusive.
  function automatic int mul_lat(input logic [W-1:0] y);
`ifdef ALU_MUL_EARLY_TERM_EN
    int hi;
    if (y == 0) return 1;
    hi = 0;
    for (int i = 0; i < W; i++) if (y[i]) hi = i;
    return hi + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", {63'b0, done}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, {32'b0, result}, {32'b0, e.res});
        chk({e.name, "_zero"}, {63'b0, zero}, {63'b0, (e.res == 0)});
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one request when idle; called at posedge+1.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit use_exp, input logic [W-1:0] ex, input string name);
    int n = 0;
    int lat;
    exp_t e;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    if (busy) chk("issue_timeout", {63'b0, busy}, 64'd0);
    op = o; a = x; b = y; start = 1'b1;
    lat = (o == 3'b011) ? mul_lat(y) : 1;
    e.res = use_exp ? ex : model(o, x, y);
    e.cyc = cyc + lat;
    e.name = name;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, bc;
    logic [2:0] ops [8];
    ops = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b101, 3'b011};

    #12;
    chk("por_busy", {63'b0, busy}, 64'd0);
    chk("por_zero", {63'b0, zero}, 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Directed single-cycle ops
    issue(3'b010, 7, 5, 1, 32'd12, "add");
    issue(3'b110, 5, 7, 1, 32'hFFFF_FFFE, "sub_neg");
    issue(3'b110, 9, 9, 1, 32'd0, "sub_zero");
    issue(3'b000, 32'hF0F0, 32'hFF00, 1, 32'hF000, "and");
    issue(3'b001, 32'hF0F0, 32'hFF00, 1, 32'hFFF0, "or");
    issue(3'b111, 32'hFFFF_FFFF, 1, 1, 32'd1, "slt_neg");
    issue(3'b111, 1, 32'hFFFF_FFFF, 1, 32'd0, "slt_pos");
    issue(3'b010, 3, 4, 1, 32'd7, "add_pre_rsv");
    issue(3'b100, 32'h1234, 32'h5678, 1, 32'd0, "reserved");
    drain();

    // Multiply with busy-duration check
    issue(3'b011, 12345, 6789, 1, 32'd83810205, "mul");
    bc = 0; n = 0;
    while (!done && n < 200) begin if (busy) bc++; @(posedge clk); #1; n++; end
    chk("mul_busy_cycles", 64'(bc), 64'(mul_lat(6789) - 1));
    drain();
    issue(3'b011, 32'hFFFF_FFFF, 2, 1, 32'hFFFF_FFFE, "mul_trunc");
    drain();

    // start while busy is ignored
    issue(3'b011, 12345, 6789, 1, 32'd83810205, "mul_ignore");
    for (int i = 0; i < 6; i++) begin
      op = 3'b010; a = $urandom; b = $urandom; start = i[0];
      @(posedge clk); #1;
    end
    start = 1'b0;
    // back-to-back in the done cycle
    n = 0;
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    chk("b2b_done_seen", {63'b0, done}, 64'd1);
    issue(3'b110, 10, 3, 1, 32'd7, "b2b_sub");
    drain();

`ifdef ALU_MUL_EARLY_TERM_EN
    issue(3'b011, 32'h1234, 0, 1, 32'd0, "et_b0");
    issue(3'b011, 99, 1, 1, 32'd99, "et_b1");
    issue(3'b011, 3, 32'h8000_0000, 1, 32'h8000_0000, "et_msb");
    drain();
`endif

    // Randomized mix
    for (int i = 0; i < 150; i++) begin
      logic [2:0] o;
      logic [W-1:0] y;
      o = ops[$urandom_range(0, 7)];
      y = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      issue(o, $urandom, y, 0, '0, "rand");
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();

    // Reset mid-multiply aborts without a done
    issue(3'b010, 1, 1, 1, 32'd2, "pre_rst");
    drain();
    issue(3'b011, 32'hABCD, 32'hFFFF_FFFF, 1, 32'd0, "mul_abort");
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_result", {32'b0, result}, 64'd0);
    chk("rst_zero", {63'b0, zero}, 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_busy", {63'b0, busy}, 64'd0);
    issue(3'b001, 32'h10, 32'h01, 1, 32'h11, "post_rst_or");
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that sits directly downstream of the ALU controller and consumes its 3-bit AluOperation code.
- Operands are registered on a start strobe, and the result comes back with a one-cycle done pulse.
- Single-cycle ops (add/sub/and/or/slt) complete in 1 cycle.
- The controller's spare code 3'b011 selects an iterative shift-add multiply (low WIDTH bits), which holds busy for WIDTH cycles.

Parameters:
- WIDTH, 32, operand/result width in bits; must be at least 2.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request; sampled only when busy=0.
- AluOperation  input  3  operation code: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 mul; 100/101 reserved.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- busy  output  1  high while a multiply is iterating.
- done  output  1  one-cycle pulse; result and zero are valid in that cycle.
- result  output  WIDTH  registered result, held until the next done.
- zero  output  1  registered flag, (result == 0).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, result=0, zero=1; internal accumulator, shifted operands and counter all cleared.
  - Reset asserted mid-multiply aborts it; no done is produced.
- States:
  - IDLE: busy=0.
  - MUL: busy=1.
- IDLE, start=1, op in {010,110,000,001,111,100,101}:
  - At that edge: result <= f(A,B), zero <= (f==0), done <= 1; stay in IDLE.
  - Latency is 1 edge.
- Arithmetic rules:
  - add/sub: modulo 2**WIDTH, no overflow output.
  - slt: two's-complement signed compare; result = {WIDTH-1 zeros, A<B}.
  - Reserved codes: result = 0, done pulses as normal.
- IDLE, start=1, op=011:
  - Capture Ar=A, Br=B, acc=0, cnt=0; go to MUL; done=0.
- MUL, each edge:
  - acc <= acc + (Br[0] ? Ar : 0), truncated to WIDTH.
  - Ar <= Ar<<1; Br <= Br>>1; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: result <= final acc, zero updated, done <= 1, go to IDLE.
- Multiply latency: WIDTH+1 edges from the start edge to done high; busy is high for WIDTH cycles.
- done is deasserted on every edge where no completion occurs.
- start while busy=1 is ignored entirely; inputs are not sampled.
- start in the done cycle: accepted normally (state is IDLE, busy=0), giving back-to-back operation.
- result/zero change only on completion edges or reset.
- A and B may change freely after the start edge; the multiply uses the captured values.

Optional Feature:
- Macro: ALU_MUL_EARLY_TERM_EN.
- When defined, a multiply completes as soon as the remaining multiplier bits are zero:
  - At capture, if B==0: complete at the start edge (result=0, done next cycle, latency 1, busy never rises).
  - In MUL: complete on the edge where Br>>1 == 0 (after applying that iteration's add).
  - Latency = 1 + (index of the highest set bit of B) + 1 edges. Example: B=1 gives done after 2 edges.
- When not defined, a multiply always takes exactly WIDTH iterations, regardless of operand values.

Test Plan (WIDTH=32):
- Reset: rst=0 mid-multiply (cycle 10 of 32), then release -> busy=0, done=0, result=0, zero=1; no done pulse follows.
- Single-cycle ops:
  - 010 with 7, 5 -> 12.
  - 110 with 5, 7 -> 0xFFFFFFFE, zero=0.
  - 110 with 9, 9 -> 0, zero=1.
  - 000 with 0xF0F0, 0xFF00 -> 0xF000.
  - 001 with the same operands -> 0xFFF0.
  - Each gives done exactly one cycle after start.
- slt signed: A=0xFFFFFFFF, B=1 -> 1; A=1, B=0xFFFFFFFF -> 0; code 100 -> 0 with a done pulse.
- Multiply: A=12345, B=6789 -> 83810205.
  - Without the macro: busy high for 32 cycles, done at edge 33.
  - A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE (truncation).
- Handshake: start pulsed with add during busy -> ignored, multiply result unaffected; start in the done cycle with sub 10, 3 -> 7 one cycle later.
- Early termination (macro on):
  - B=0 -> done after 1 edge, result 0.
  - B=1, A=99 -> done after 2 edges, result 99.
  - B=0x80000000 -> 33 edges.
